ras_ctrl: RTL and testbench

- Speculation controller for the frontend return address stack (RAS).
- Classifies decoded jal/jalr as call, return or neither, and drives write/read addresses of a separate RAS storage array.
- Keeps a circular queue of pointer checkpoints, one per in-flight branch; restores the stack pointer on mispredict and frees the checkpoint on commit.
- Sits between decode, the RAS storage and the branch resolution/commit logic.

---
 rtl/rv32i_types.sv | 38 +++
 rtl/ras_ckpt_queue.sv | 45 ++++
 rtl/ras_ctrl.sv | 113 +++++++++++
 tb/tb_ras_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: RV32I opcodes, link-register constants, RAS FSM states and checkpoint record.
// RAS_TOS_REPAIR_EN adds the saved top-of-stack storage word to every checkpoint.
package rv32i_types;
   localparam int DEF_RAS_DEPTH = 32;
   localparam int DEF_CKPT_DEPTH = 8;
   localparam int RAS_PTR_W = $clog2(DEF_RAS_DEPTH);
   localparam logic [4:0] LINK_X1 = 5'd1;
   localparam logic [4:0] LINK_X5 = 5'd5;
   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011
   } rv32i_op_t;
   typedef enum logic {RUN, RECOVER} ras_state_t;
   typedef struct packed {
      logic [RAS_PTR_W-1:0] sp;
      logic [RAS_PTR_W:0]   cnt;
      logic                 push;
      logic                 pop;
`ifdef RAS_TOS_REPAIR_EN
      logic [31:0]          tos;
`endif
   } ras_ckpt_t;
   function automatic logic is_link(input logic [4:0] r);
      return r == LINK_X1 || r == LINK_X5;
   endfunction
   // occupancy saturates at full depth: overflow overwrites the oldest entry
   function automatic logic [RAS_PTR_W:0] cnt_step(input logic [RAS_PTR_W:0] c, input logic push, input logic pop);
      return push ? ((c == (RAS_PTR_W+1)'(DEF_RAS_DEPTH)) ? c : c + (RAS_PTR_W+1)'(1))
                  : (pop ? c - (RAS_PTR_W+1)'(1) : c);
   endfunction
endpackage

// File: rtl/ras_ckpt_queue.sv
// ras_ckpt_queue: circular buffer of RAS pointer checkpoints with alloc, free-oldest and truncate-to-tag.
module ras_ckpt_queue
   import rv32i_types::*;
#(
   parameter int DEPTH = DEF_CKPT_DEPTH,
   localparam int TW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          alloc,
   input  ras_ckpt_t     alloc_data,
   input  logic          free,
   input  logic          trunc,
   input  logic [TW-1:0] trunc_tag,
   output logic [TW-1:0] tail,
   output logic          full,
   output logic          tag_ok,
   output ras_ckpt_t     rd_data
);
   ras_ckpt_t mem [DEPTH];
   logic [TW-1:0] head, off;
   logic [TW:0] count;
   logic freeing;
   always_comb begin
      off = trunc_tag - head;
      tag_ok = {1'b0, off} < count;
      full = count == (TW+1)'(DEPTH);
      freeing = free && count != '0;
      rd_data = mem[trunc_tag];
   end
   // truncation keeps the mispredicted entry itself and drops everything younger
   always_ff @(posedge clk)
      if (rst || clr) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         head <= head + TW'(freeing);
         tail <= trunc ? trunc_tag + TW'(1) : tail + TW'(alloc);
         count <= (trunc ? {1'b0, off} + (TW+1)'(1) : count + (TW+1)'(alloc)) - (TW+1)'(freeing);
      end
   always_ff @(posedge clk)
      if (alloc && !trunc) mem[tail] <= alloc_data;
endmodule

// File: rtl/ras_ctrl.sv
// ras_ctrl: speculative return-address-stack controller with per-branch pointer checkpoints.
// Define RAS_TOS_REPAIR_EN to rewrite the saved top-of-stack word during recovery.
module ras_ctrl
   import rv32i_types::*;
#(
   parameter int RAS_DEPTH = DEF_RAS_DEPTH,
   parameter int CKPT_DEPTH = DEF_CKPT_DEPTH,
   localparam int PTR_W = $clog2(RAS_DEPTH),
   localparam int TAG_W = $clog2(CKPT_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dec_valid,
   output logic             dec_ready,
   input  rv32i_op_t        dec_opcode,
   input  logic [4:0]       dec_rd,
   input  logic [4:0]       dec_rs1,
   input  logic [31:0]      dec_pc,
   input  logic             dec_is_br,
   output logic [TAG_W-1:0] ckpt_tag,
   output logic             pred_valid,
   output logic [31:0]      pred_target,
   output logic             ras_we,
   output logic [PTR_W-1:0] ras_waddr,
   output logic [31:0]      ras_wdata,
   output logic [PTR_W-1:0] ras_raddr,
   input  logic [31:0]      ras_rdata,
   input  logic             res_valid,
   input  logic [TAG_W-1:0] res_tag,
   input  logic             res_mispredict,
   input  logic             commit_valid,
   input  logic             flush
);
   ras_state_t state, state_nx;
   logic [PTR_W-1:0] sp, rsp, rep_addr;
   logic [PTR_W:0] cnt, rcnt;
   logic [TAG_W-1:0] tail;
   logic [31:0] rep_data;
   logic is_call, is_ret, mis, accept, push, pop, alloc, full, tag_ok, rep_we;
   ras_ckpt_t ck_wr, ck_rd;
`ifdef RAS_TOS_REPAIR_EN
   logic [PTR_W-1:0] rec_addr;
   logic [31:0] rec_data;
   always_ff @(posedge clk)
      if (mis) begin
         rec_addr <= ck_rd.sp - PTR_W'(1);
         rec_data <= ck_rd.tos;
      end
   assign rep_we = !rst && !flush && state == RECOVER;
   assign rep_addr = rec_addr;
   assign rep_data = rec_data;
`else
   assign rep_we = 1'b0;
   assign rep_addr = '0;
   assign rep_data = '0;
`endif
   always_comb begin
      is_call = (dec_opcode == OP_JAL || dec_opcode == OP_JALR) && is_link(dec_rd);
      is_ret = dec_opcode == OP_JALR && is_link(dec_rs1) && !is_link(dec_rd);
      mis = !rst && !flush && res_valid && res_mispredict && tag_ok;
      dec_ready = !rst && state == RUN && !(dec_is_br && full);
      accept = dec_valid && dec_ready && !flush && !mis;
      push = accept && is_call;
      pop = accept && is_ret && cnt != '0;
      alloc = accept && dec_is_br;
      state_nx = mis ? RECOVER : RUN;
      // restore the pre-branch pointer, then replay the branch's own push/pop
      rsp = ck_rd.sp + PTR_W'(ck_rd.push) - PTR_W'(ck_rd.pop);
      rcnt = cnt_step(ck_rd.cnt, ck_rd.push, ck_rd.pop);
      ck_wr.sp = sp;
      ck_wr.cnt = cnt;
      ck_wr.push = push;
      ck_wr.pop = pop;
`ifdef RAS_TOS_REPAIR_EN
      ck_wr.tos = ras_rdata;
`endif
      ras_we = push || rep_we;
      ras_waddr = rst ? '0 : (rep_we ? rep_addr : sp);
      ras_wdata = rst ? '0 : (rep_we ? rep_data : dec_pc + 32'd4);
      ras_raddr = rst ? '0 : sp - PTR_W'(1);
      pred_valid = pop;
      pred_target = pop ? ras_rdata : '0;
      ckpt_tag = rst ? '0 : tail;
   end
   always_ff @(posedge clk)
      if (rst) state <= RUN;
      else state <= state_nx;
   always_ff @(posedge clk)
      if (rst || flush) begin
         sp <= '0;
         cnt <= '0;
      end else if (mis) begin
         sp <= rsp;
         cnt <= rcnt;
      end else if (push || pop) begin
         sp <= push ? sp + PTR_W'(1) : sp - PTR_W'(1);
         cnt <= cnt_step(cnt, push, pop);
      end
   ras_ckpt_queue #(.DEPTH(CKPT_DEPTH)) u_queue (
      .clk(clk),
      .rst(rst),
      .clr(flush),
      .alloc(alloc),
      .alloc_data(ck_wr),
      .free(commit_valid),
      .trunc(mis),
      .trunc_tag(res_tag),
      .tail(tail),
      .full(full),
      .tag_ok(tag_ok),
      .rd_data(ck_rd)
   );
endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: directed plus random stimulus checked against a behavioural RAS/checkpoint model.
module tb_ras_ctrl;
   import rv32i_types::*;
   localparam int RD = 32;
   localparam int CK = 8;
   typedef struct {int sp; int cnt; bit push; bit pop;} mck_t;
   logic clk = 0, rst = 1, dec_valid = 0, dec_is_br = 0, res_valid = 0, res_mispredict = 0, commit_valid = 0, flush = 0;
   rv32i_op_t dec_opcode = OP_IMM;
   logic [4:0] dec_rd = 0, dec_rs1 = 0;
   logic [31:0] dec_pc = 0;
   logic [2:0] res_tag = 0;
   logic dec_ready, pred_valid, ras_we;
   logic [2:0] ckpt_tag;
   logic [31:0] pred_target, ras_wdata, ras_rdata;
   logic [4:0] ras_waddr, ras_raddr;
   logic [31:0] ras_mem [RD];
   logic [31:0] m_stack [RD];
   mck_t q[$];
   int m_sp, m_cnt, m_head, n_assert, n_fail;
   bit m_rec;
   always #5 clk = ~clk;
   always @(posedge clk) if (ras_we) ras_mem[ras_waddr] <= ras_wdata;
   assign ras_rdata = ras_mem[ras_raddr];
   ras_ctrl dut (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
      .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_pc(dec_pc), .dec_is_br(dec_is_br), .ckpt_tag(ckpt_tag),
      .pred_valid(pred_valid), .pred_target(pred_target), .ras_we(ras_we), .ras_waddr(ras_waddr),
      .ras_wdata(ras_wdata), .ras_raddr(ras_raddr), .ras_rdata(ras_rdata), .res_valid(res_valid),
      .res_tag(res_tag), .res_mispredict(res_mispredict), .commit_valid(commit_valid), .flush(flush)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic bit link(input logic [4:0] r);
      return r == 5'd1 || r == 5'd5;
   endfunction
   function automatic logic [4:0] pick_reg();
      int k = $urandom_range(0, 3);
      return k == 0 ? 5'd0 : k == 1 ? 5'd1 : k == 2 ? 5'd5 : 5'($urandom_range(0, 31));
   endfunction
   task automatic idle();
      dec_valid = 0; dec_is_br = 0; res_valid = 0; res_mispredict = 0; commit_valid = 0; flush = 0;
   endtask
   task automatic dec(input rv32i_op_t op, input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] pc, input logic br);
      idle();
      dec_valid = 1; dec_opcode = op; dec_rd = rd; dec_rs1 = rs1; dec_pc = pc; dec_is_br = br;
   endtask
   // one clock: check outputs against the model, clock, then advance the model
   task automatic cycle();
      bit rdy, mis, acc, psh, pp, docommit;
      int idx;
      mck_t e;
      #1;
      if (rst) begin
         chk("rst_ready", 32'(dec_ready), 0);
         chk("rst_we", 32'(ras_we), 0);
         chk("rst_waddr", 32'(ras_waddr), 0);
         chk("rst_wdata", ras_wdata, 0);
         chk("rst_raddr", 32'(ras_raddr), 0);
         chk("rst_pv", 32'(pred_valid), 0);
         chk("rst_target", pred_target, 0);
         chk("rst_tag", 32'(ckpt_tag), 0);
      end else begin
         rdy = !m_rec && !(dec_is_br && q.size() == CK);
         idx = -1;
         for (int i = 0; i < q.size(); i++) if ((m_head + i) % CK == int'(res_tag)) idx = i;
         mis = res_valid && res_mispredict && !flush && idx >= 0;
         acc = dec_valid && rdy && !flush && !mis;
         psh = acc && (dec_opcode == OP_JAL || dec_opcode == OP_JALR) && link(dec_rd);
         pp = acc && dec_opcode == OP_JALR && link(dec_rs1) && !link(dec_rd) && m_cnt > 0;
         chk("dec_ready", 32'(dec_ready), 32'(rdy));
         chk("ras_we", 32'(ras_we), 32'(psh));
         if (psh) begin
            chk("ras_waddr", 32'(ras_waddr), m_sp);
            chk("ras_wdata", ras_wdata, dec_pc + 4);
         end
         chk("pred_valid", 32'(pred_valid), 32'(pp));
         if (pp) chk("pred_target", pred_target, m_stack[(m_sp + RD - 1) % RD]);
         chk("ras_raddr", 32'(ras_raddr), (m_sp + RD - 1) % RD);
         chk("ckpt_tag", 32'(ckpt_tag), (m_head + q.size()) % CK);
      end
      @(posedge clk);
      if (rst || flush) begin
         m_sp = 0; m_cnt = 0; m_head = 0; m_rec = 0;
         q.delete();
      end else begin
         docommit = commit_valid && q.size() > 0;
         if (mis) begin
            e = q[idx];
            while (q.size() > idx + 1) void'(q.pop_back());
            m_sp = (e.sp + int'(e.push) - int'(e.pop) + RD) % RD;
            m_cnt = e.push ? (e.cnt < RD ? e.cnt + 1 : RD) : e.cnt - int'(e.pop);
            m_rec = 1;
         end else begin
            m_rec = 0;
            if (acc && dec_is_br) q.push_back('{m_sp, m_cnt, psh, pp});
            if (psh) begin
               m_stack[m_sp] = dec_pc + 4;
               m_sp = (m_sp + 1) % RD;
               if (m_cnt < RD) m_cnt++;
            end else if (pp) begin
               m_sp = (m_sp + RD - 1) % RD;
               m_cnt--;
            end
         end
         if (docommit) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % CK;
         end
      end
      #1;
   endtask
   initial begin
      int r0, npv, k;
      rv32i_op_t op;
      for (int i = 0; i < RD; i++) begin
         ras_mem[i] = 0;
         m_stack[i] = 0;
      end
      dec(OP_JAL, 5'd1, 5'd0, 32'h100, 1);
      cycle();
      cycle();
      rst = 0;
      dec(OP_JAL, 5'd1, 5'd0, 32'h100, 0);
      #1;
      chk("tp_call_we", 32'(ras_we), 1);
      chk("tp_call_waddr", 32'(ras_waddr), 0);
      chk("tp_call_wdata", ras_wdata, 32'h104);
      cycle();
      dec(OP_JALR, 5'd0, 5'd1, 32'h200, 0);
      #1;
      chk("tp_ret_pv", 32'(pred_valid), 1);
      chk("tp_ret_target", pred_target, 32'h104);
      cycle();
      idle();
      #1;
      chk("tp_ret_sp", 32'(ras_raddr), 31);
      cycle();
      dec(OP_JALR, 5'd0, 5'd5, 32'h204, 0);
      #1;
      chk("empty_pv", 32'(pred_valid), 0);
      chk("empty_we", 32'(ras_we), 0);
      cycle();
      idle();
      #1;
      chk("empty_sp", 32'(ras_raddr), 31);
      cycle();
      for (int i = 0; i < 33; i++) begin
         dec(OP_JAL, 5'd1, 5'd0, 32'h1000 + 32'(i * 4), 0);
         if (i == 32) begin
            #1;
            chk("ovf_wrap_waddr", 32'(ras_waddr), 0);
         end
         cycle();
      end
      npv = 0;
      for (int i = 0; i < 33; i++) begin
         dec(OP_JALR, 5'd0, 5'd1, 32'h2000, 0);
         #1;
         if (i == 0) chk("ovf_first_target", pred_target, 32'h1084);
         if (i == 32) chk("ovf_last_pv", 32'(pred_valid), 0);
         npv += int'(pred_valid);
         cycle();
      end
      chk("ovf_pv_count", npv, 32);
      idle();
      #1;
      r0 = int'(ras_raddr);
      dec(OP_JAL, 5'd1, 5'd0, 32'h300, 1);
      #1;
      chk("ck_a_tag", 32'(ckpt_tag), 0);
      cycle();
      for (int i = 0; i < 3; i++) begin
         dec(OP_JAL, 5'd5, 5'd0, 32'h400 + 32'(i * 4), 0);
         cycle();
      end
      idle();
      res_valid = 1; res_mispredict = 1; res_tag = 0;
      cycle();
      idle();
      #1;
      chk("rec_ready", 32'(dec_ready), 0);
      chk("rec_sp", 32'(ras_raddr), (r0 + 1) % RD);
      cycle();
      dec(OP_BRANCH, 5'd0, 5'd0, 32'h500, 1);
      #1;
      chk("rec_tail", 32'(ckpt_tag), 1);
      cycle();
      idle();
      commit_valid = 1;
      cycle();
      cycle();
      for (int i = 0; i < 8; i++) begin
         dec(OP_BRANCH, 5'd0, 5'd0, 32'h600 + 32'(i * 4), 1);
         cycle();
      end
      dec(OP_BRANCH, 5'd0, 5'd0, 32'h700, 1);
      commit_valid = 1;
      #1;
      chk("full_ready", 32'(dec_ready), 0);
      cycle();
      dec(OP_BRANCH, 5'd0, 5'd0, 32'h700, 1);
      #1;
      chk("full_next_ready", 32'(dec_ready), 1);
      chk("full_next_tag", 32'(ckpt_tag), 2);
      cycle();
      dec(OP_JAL, 5'd1, 5'd0, 32'h800, 0);
      res_valid = 1; res_mispredict = 1; res_tag = 5; flush = 1;
      #1;
      chk("flush_we", 32'(ras_we), 0);
      cycle();
      idle();
      #1;
      chk("flush_sp", 32'(ras_raddr), 31);
      chk("flush_tag", 32'(ckpt_tag), 0);
      chk("flush_ready", 32'(dec_ready), 1);
      cycle();
      for (int n = 0; n < 3000; n++) begin
         idle();
         if ($urandom_range(0, 9) < 7) begin
            k = $urandom_range(0, 3);
            op = k == 0 ? OP_JAL : k == 1 ? OP_JALR : k == 2 ? OP_BRANCH : OP_IMM;
            dec(op, pick_reg(), pick_reg(), $urandom,
                (op == OP_JALR || op == OP_BRANCH) ? 1'b1 : 1'($urandom_range(0, 1)));
         end
         if ($urandom_range(0, 99) < 15) begin
            res_valid = 1;
            res_mispredict = 1'($urandom_range(0, 1));
            res_tag = 3'($urandom_range(0, 7));
         end
         commit_valid = $urandom_range(0, 99) < 25;
         flush = $urandom_range(0, 99) < 1;
         cycle();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
